// File: rtl/micro_arb_v.sv
// micro_arb_v: round-robin arbiter sharing a 4-input code mux, with a registered select/enable and a registered captured code.
module micro_arb_v #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [3:0]       i_req,
  input  logic [WIDTH-1:0] i_code_0,
  input  logic [WIDTH-1:0] i_code_1,
  input  logic [WIDTH-1:0] i_code_2,
  input  logic [WIDTH-1:0] i_code_3,
  output logic [3:0]       o_gnt,
  output logic [1:0]       o_sel_code,
  output logic             o_en,
  output logic [WIDTH-1:0] o_code,
  output logic             o_valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] CNT_MAX = 8'(HOLD_CYCLES - 1);
  state_t state, state_nx;
  logic [1:0] last, last_nx, sel_nx, win, idx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] gnt_nx;
  logic en_nx, found, hold;
  logic [WIDTH-1:0] mux_code;
  // last always equals the current owner while granted, so one search from last+1 serves both states
  always_comb begin
    found = 1'b0;
    win = last;
    idx = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    state_nx = state;
    gnt_nx = o_gnt;
    sel_nx = o_sel_code;
    en_nx = o_en;
    cnt_nx = cnt;
    last_nx = last;
    hold = state == GRANT && i_req[o_sel_code] && cnt < CNT_MAX;
    if (hold) begin
      cnt_nx = cnt + 8'd1;
    end else if (found) begin
      state_nx = GRANT;
      gnt_nx = 4'b0001 << win;
      sel_nx = win;
      en_nx = 1'b1;
      cnt_nx = 8'd0;
      last_nx = win;
    end else begin
      state_nx = IDLE;
      gnt_nx = 4'b0000;
      en_nx = 1'b0;
      cnt_nx = 8'd0;
    end
  end
  always_comb
    mux_code = o_sel_code == 2'd0 ? i_code_0 :
               o_sel_code == 2'd1 ? i_code_1 :
               o_sel_code == 2'd2 ? i_code_2 : i_code_3;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_gnt <= 4'b0000;
      o_sel_code <= 2'b00;
      o_en <= 1'b0;
      o_code <= '0;
      o_valid <= 1'b0;
      cnt <= 8'd0;
      last <= 2'd3;
    end else begin
      state <= state_nx;
      o_gnt <= gnt_nx;
      o_sel_code <= sel_nx;
      o_en <= en_nx;
      o_code <= o_en ? mux_code : '0;
      o_valid <= o_en;
      cnt <= cnt_nx;
      last <= last_nx;
    end
  end
endmodule

// File: doc/micro_arb_v.md
Name: micro_arb_v

Overview:
Round-robin arbiter and sequencer that shares the 4-input 8-bit code-select mux (i_code_0..3 -> o_code) among four requesters. It generates the mux select and enable from registered grant state and captures the selected code into a registered output with a valid strobe. It sits directly in front of the code mux, replacing static select/enable drive.

Parameters:
WIDTH, 8, code width in bits.
HOLD_CYCLES, 4, maximum consecutive grant cycles per requester. Legal range 1..255. Counter width is 8 bits.

Ports:
i_clk  input  1  system clock; all state updates on rising edge
i_rst_n  input  1  reset; asynchronous, active-low
i_req  input  4  level request per requester; bit n requests i_code_n
i_code_0  input  WIDTH  code from requester 0
i_code_1  input  WIDTH  code from requester 1
i_code_2  input  WIDTH  code from requester 2
i_code_3  input  WIDTH  code from requester 3
o_gnt  output  4  one-hot grant, registered; 0 when idle
o_sel_code  output  2  mux select, registered; index of granted requester
o_en  output  1  mux enable, registered; 1 in GRANT state
o_code  output  WIDTH  registered selected code; 0 when not valid
o_valid  output  1  o_code holds a granted code

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=IDLE, o_gnt=0, o_sel_code=2'b00, o_en=0, o_code=0, o_valid=0, hold count=0, last-granted pointer=3, so requester 0 has first priority.
- Round-robin pick: search i_req starting at (last+1) mod 4, wrapping. The first set bit wins, and last is updated to the winner when the grant is issued.
- IDLE: at an edge with i_req!=0, go to GRANT with the picked winner. o_gnt, o_sel_code and o_en are updated at that edge. Hold count=0. With i_req=0, stay in IDLE.
- GRANT, with cur = granted index, evaluated at each edge:
  - i_req[cur]=1 and count<HOLD_CYCLES-1: stay on cur and increment count.
  - i_req[cur]=0 or count==HOLD_CYCLES-1: re-arbitrate from (cur+1) over the current i_req.
    - Winner exists: grant it at this edge, with no idle bubble, and count=0.
    - Winner is cur again (sole requester at hold expiry): re-grant cur with count=0.
    - No winner: go to IDLE, o_gnt=0, o_en=0, o_sel_code holds its last value.
- Grant latency: a request sampled at edge k is granted from edge k, visible after k, if the arbiter is free.
- A dropped request is released one cycle after i_req falls; the dropped requester receives one extra cycle of grant.
- Data path: at each edge, o_valid<=o_en and o_code<=o_en ? i_code_[o_sel_code] : 0.
  - o_code/o_valid lag the grant by one cycle. The code sampled is the value present during the grant cycle.
- HOLD_CYCLES=1: a requester is granted for exactly 1 cycle before rotation. A sole requester stays granted continuously.
- o_gnt is always one-hot or zero, and o_gnt=(1<<o_sel_code) whenever o_en=1.
- Requests from non-granted requesters never preempt a grant before release or expiry.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge. The first grant after reset starts search at requester 0.
- i_req bits of X/Z are not supported.

Test Plan:
- Reset then i_req=4'b0000 for 5 cycles -> o_gnt=0, o_en=0, o_valid=0, o_code=8'h00 throughout. Assert i_rst_n=0 mid-grant -> all outputs 0 without a clock edge.
- i_req=4'b0100, i_code_2=8'hA5 held 10 cycles, HOLD_CYCLES=4 -> o_gnt=4'b0100, o_sel_code=2 from the cycle after the request is sampled. o_valid=1 and o_code=8'hA5 from the cycle after that, continuous with no drop at hold expiry.
- i_req=4'b1111, codes 8'h10/8'h11/8'h12/8'h13, HOLD_CYCLES=4 -> grants rotate 0,1,2,3,0, each exactly 4 cycles with no gaps. o_code sequence is 8'h10 x4, 8'h11 x4, 8'h12 x4, 8'h13 x4, then 8'h10, lagging o_gnt by one cycle.
- Requester 1 granted and i_req[1] drops after 2 grant cycles while i_req[3]=1 -> grant moves to 3 one cycle after the drop with no idle cycle. The next request by 0 is served after 3, following wrap order.
- HOLD_CYCLES=1, i_req=4'b0101 -> o_gnt alternates 4'b0001, 4'b0100 every cycle. Remove all requests -> IDLE, o_en=0 next edge, o_valid=0 one edge later.
- After the last grant to 3 and a return to IDLE, i_req=4'b1001 -> requester 0 is granted first (pointer wrap 3->0).
